// File: rtl/pooling_stream_unit.sv
// pooling_stream_unit: streaming signed max-pooling engine.
// One window element per channel arrives per accepted beat; after WIN_LEN
// beats (or an early in_last) the per-lane maximum is registered on out_data.
// The output register is bypassable on drain, so one beat per cycle is sustained.
// Optional build macro POOL_SUM_EN adds a pool_mode input selecting saturated
// sum pooling for a window (sampled on its first beat).
module pooling_stream_unit #(
  parameter int DATA_WIDTH = 6,
  parameter int CHANNELS   = 4,
  parameter int WIN_LEN    = 9,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [CHANNELS*DATA_WIDTH-1:0] in_data,
  input  logic                           in_last,
`ifdef POOL_SUM_EN
  input  logic                           pool_mode,
`endif
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [CHANNELS*DATA_WIDTH-1:0] out_data,
  output logic [CNT_WIDTH-1:0]           out_count,
  output logic                           busy
);

  localparam logic signed [DATA_WIDTH-1:0] MIN_VAL  = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [CNT_WIDTH-1:0]         LAST_IDX = CNT_WIDTH'(WIN_LEN - 1);
  localparam logic [CNT_WIDTH-1:0]         CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0]         CNT_ZERO = {CNT_WIDTH{1'b0}};

`ifdef POOL_SUM_EN
  localparam int SW = DATA_WIDTH + CNT_WIDTH;
  localparam logic signed [DATA_WIDTH-1:0] MAX_VAL = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [SW-1:0] SUM_MAX = {{CNT_WIDTH{1'b0}}, MAX_VAL};
  localparam logic signed [SW-1:0] SUM_MIN = {{CNT_WIDTH{1'b1}}, MIN_VAL};

  // Clamp a widened window sum back into the lane data range.
  function automatic logic [DATA_WIDTH-1:0] sat_lane(input logic signed [SW-1:0] v);
    logic [DATA_WIDTH-1:0] r;
    if (v > SUM_MAX) begin
      r = MAX_VAL;
    end else if (v < SUM_MIN) begin
      r = MIN_VAL;
    end else begin
      r = v[DATA_WIDTH-1:0];
    end
    return r;
  endfunction

  logic                         mode_q, mode_d, mode_eff_s;
  logic signed [SW-1:0]         sum_q [CHANNELS];
  logic signed [SW-1:0]         sum_d [CHANNELS];
  logic signed [SW-1:0]         sum_new_s [CHANNELS];
`endif

  logic                           accept_s, close_s, first_s;
  logic signed [DATA_WIDTH-1:0]   lane_s    [CHANNELS];
  logic signed [DATA_WIDTH-1:0]   acc_eff_s [CHANNELS];
  logic signed [DATA_WIDTH-1:0]   max_s     [CHANNELS];
  logic signed [DATA_WIDTH-1:0]   acc_q     [CHANNELS];
  logic signed [DATA_WIDTH-1:0]   acc_d     [CHANNELS];
  logic [CNT_WIDTH-1:0]           cnt_q, cnt_d;
  logic                           out_valid_q, out_valid_d;
  logic [CHANNELS*DATA_WIDTH-1:0] out_data_q, out_data_d, result_s;
  logic [CNT_WIDTH-1:0]           out_count_q, out_count_d;
  logic                           busy_q, busy_d;

  assign in_ready = !out_valid_q || out_ready;
  assign accept_s = in_valid && in_ready;
  assign first_s  = (cnt_q == CNT_ZERO);
  assign close_s  = accept_s && ((cnt_q == LAST_IDX) || in_last);

  // Per-lane datapath: running max (and sum) including the current beat.
  always_comb begin
`ifdef POOL_SUM_EN
    mode_eff_s = first_s ? pool_mode : mode_q;
`endif
    result_s = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      lane_s[c]    = in_data[c*DATA_WIDTH +: DATA_WIDTH];
      acc_eff_s[c] = first_s ? MIN_VAL : acc_q[c];
      max_s[c]     = (lane_s[c] > acc_eff_s[c]) ? lane_s[c] : acc_eff_s[c];
`ifdef POOL_SUM_EN
      sum_new_s[c] = (first_s ? {SW{1'b0}} : sum_q[c]) +
                     {{CNT_WIDTH{lane_s[c][DATA_WIDTH-1]}}, lane_s[c]};
      if (mode_eff_s) begin
        result_s[c*DATA_WIDTH +: DATA_WIDTH] = sat_lane(sum_new_s[c]);
      end else begin
        result_s[c*DATA_WIDTH +: DATA_WIDTH] = max_s[c];
      end
`else
      result_s[c*DATA_WIDTH +: DATA_WIDTH] = max_s[c];
`endif
    end
  end

  // Next-state: accumulate on accept, register result on close, drain output.
  always_comb begin
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;
`ifdef POOL_SUM_EN
    mode_d      = mode_q;
    sum_d       = sum_q;
`endif
    if (close_s) begin
      cnt_d       = CNT_ZERO;
      out_valid_d = 1'b1;
      out_data_d  = result_s;
      out_count_d = cnt_q + CNT_ONE;
      for (int c = 0; c < CHANNELS; c++) begin
        acc_d[c] = MIN_VAL;
      end
    end else if (accept_s) begin
      cnt_d = cnt_q + CNT_ONE;
      acc_d = max_s;
`ifdef POOL_SUM_EN
      sum_d  = sum_new_s;
      mode_d = mode_eff_s;
`endif
      if (out_valid_q && out_ready) begin
        out_valid_d = 1'b0;
      end else begin
        out_valid_d = out_valid_q;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
    busy_d = (cnt_d != CNT_ZERO);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= CNT_ZERO;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_count_q <= CNT_ZERO;
      busy_q      <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
        acc_q[c] <= MIN_VAL;
      end
    end else begin
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
      busy_q      <= busy_d;
      acc_q       <= acc_d;
    end
  end

`ifdef POOL_SUM_EN
  // Sum-mode accumulator and window mode flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
        sum_q[c] <= {SW{1'b0}};
      end
    end else begin
      mode_q <= mode_d;
      sum_q  <= sum_d;
    end
  end
`endif

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_count = out_count_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_pooling_stream_unit.sv
// Directed self-checking bench for pooling_stream_unit (default parameters).
module tb_pooling_stream_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [23:0] in_data = 24'd0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [23:0] out_data;
  logic [7:0]  out_count;
  logic        busy;
`ifdef POOL_SUM_EN
  logic        pool_mode = 1'b0;
`endif

  int n_checks = 0;
  int n_errors = 0;

  pooling_stream_unit dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
`ifdef POOL_SUM_EN
    .pool_mode(pool_mode),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_count(out_count), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int lane(input logic [23:0] v, input int c);
    logic signed [5:0] t;
    t = v[c*6 +: 6];
    return int'(t);
  endfunction

  function automatic logic [23:0] pack4(input int a, input int b, input int c, input int d);
    return {d[5:0], c[5:0], b[5:0], a[5:0]};
  endfunction

  // Present one beat (caller ensures in_ready), advance one edge, sample at +1.
  task automatic beat(input int d0, input int d1, input int d2, input int d3, input logic last);
    in_data  = pack4(d0, d1, d2, d3);
    in_last  = last;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int w1 [9] = '{3, -5, 7, 0, -1, 2, 6, -8, 1};
  int w4 [4] = '{-3, -7, -1, -9};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #12;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_count", int'(out_count), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_in_ready", int'(in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);

    // Basic 9-beat window
    for (int i = 0; i < 9; i++) begin
      beat(w1[i], -2, -2, -2, 1'b0);
      if (i == 4) check("w1_busy_mid", int'(busy), 1);
      if (i < 8) check("w1_no_early_valid", int'(out_valid), 0);
    end
    check("w1_valid", int'(out_valid), 1);
    check("w1_lane0", lane(out_data, 0), 7);
    check("w1_lane1", lane(out_data, 1), -2);
    check("w1_lane2", lane(out_data, 2), -2);
    check("w1_lane3", lane(out_data, 3), -2);
    check("w1_count", int'(out_count), 9);
    check("w1_busy_after", int'(busy), 0);
    idle(1);
    check("w1_drained", int'(out_valid), 0);

    // All lanes most-negative
    for (int i = 0; i < 9; i++) beat(-32, -32, -32, -32, 1'b0);
    check("min_valid", int'(out_valid), 1);
    for (int c = 0; c < 4; c++) check("min_lane", lane(out_data, c), -32);
    check("min_count", int'(out_count), 9);

    // Early close on beat 4, then an independent full window
    for (int i = 0; i < 4; i++) beat(w4[i], i, -32, 31 - i, i == 3);
    check("early_valid", int'(out_valid), 1);
    check("early_lane0", lane(out_data, 0), -1);
    check("early_lane1", lane(out_data, 1), 3);
    check("early_lane2", lane(out_data, 2), -32);
    check("early_lane3", lane(out_data, 3), 31);
    check("early_count", int'(out_count), 4);
    for (int i = 0; i < 9; i++) beat((i == 0) ? 5 : -10 + i, -20, 0, -1, 1'b0);
    check("after_early_lane0", lane(out_data, 0), 5);
    check("after_early_lane1", lane(out_data, 1), -20);
    check("after_early_count", int'(out_count), 9);

    // in_last on the first beat
    beat(-17, 9, -4, 0, 1'b1);
    check("first_last_count", int'(out_count), 1);
    check("first_last_lane0", lane(out_data, 0), -17);
    check("first_last_lane1", lane(out_data, 1), 9);
    check("first_last_lane2", lane(out_data, 2), -4);

    // Idle hold mid-window, then in_last on the ninth beat
    for (int i = 0; i < 3; i++) beat(i, 0, 0, 0, 1'b0);
    idle(4);
    check("hold_busy", int'(busy), 1);
    check("hold_valid", int'(out_valid), 0);
    for (int i = 3; i < 9; i++) beat(i, 0, 0, 0, i == 8);
    check("last9_valid", int'(out_valid), 1);
    check("last9_count", int'(out_count), 9);
    check("last9_lane0", lane(out_data, 0), 8);
    idle(1);
    check("last9_no_extra", int'(out_valid), 0);
    check("last9_busy", int'(busy), 0);

    // Backpressure
    out_ready = 1'b0;
    for (int i = 0; i < 9; i++) beat(i + 1, 4, -1, -32, 1'b0);
    check("bp_valid", int'(out_valid), 1);
    in_data  = pack4(20, 20, 20, 20);
    in_last  = 1'b1;
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check("bp_in_ready", int'(in_ready), 0);
      @(posedge clk);
      #1;
      check("bp_hold_valid", int'(out_valid), 1);
      check("bp_hold_lane0", lane(out_data, 0), 9);
      check("bp_hold_lane3", lane(out_data, 3), -32);
      check("bp_hold_count", int'(out_count), 9);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("bp_not_consumed", int'(busy), 0);
    out_ready = 1'b1;
    idle(1);
    check("bp_released", int'(out_valid), 0);

    // Back-to-back windows, results 9 beats apart
    for (int b = 0; b < 18; b++) begin
      beat((b < 9) ? b : -b, b, 0, 0, 1'b0);
      if (b == 8) begin
        check("b2b_first_valid", int'(out_valid), 1);
        check("b2b_first_lane0", lane(out_data, 0), 8);
      end
      if (b == 9) check("b2b_gap", int'(out_valid), 0);
      if (b == 17) begin
        check("b2b_second_valid", int'(out_valid), 1);
        check("b2b_second_lane0", lane(out_data, 0), -9);
        check("b2b_second_lane1", lane(out_data, 1), 17);
        check("b2b_second_count", int'(out_count), 9);
      end
    end

    // Drain and close in the same cycle: no bubble, data replaced
    for (int k = 0; k < 3; k++) begin
      beat(11 + k, 0, 0, 0, 1'b1);
      check("dc_valid", int'(out_valid), 1);
      check("dc_lane0", lane(out_data, 0), 11 + k);
      check("dc_count", int'(out_count), 1);
    end
    idle(1);
    check("dc_drained", int'(out_valid), 0);

    // Reset mid-window
    for (int i = 0; i < 5; i++) beat(30, 30, 30, 30, 1'b0);
    rst_n = 1'b0;
    #1;
    check("rst_mid_busy", int'(busy), 0);
    check("rst_mid_valid", int'(out_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 9; i++) begin
      beat(i + 1, -5, -5, -5, 1'b0);
      if (i == 3) check("rst_mid_no_early", int'(out_valid), 0);
    end
    check("rst_mid_result_valid", int'(out_valid), 1);
    check("rst_mid_lane0", lane(out_data, 0), 9);
    check("rst_mid_lane1", lane(out_data, 1), -5);
    check("rst_mid_count", int'(out_count), 9);

    // Reset with a pending result
    out_ready = 1'b0;
    idle(1);
    beat(7, 7, 7, 7, 1'b1);
    check("rst_pend_before", int'(out_valid), 1);
    rst_n = 1'b0;
    #1;
    check("rst_pend_valid", int'(out_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(3);
    check("rst_pend_stays_empty", int'(out_valid), 0);
    out_ready = 1'b1;

`ifdef POOL_SUM_EN
    // Sum pooling with saturation, then a max window
    pool_mode = 1'b1;
    for (int i = 0; i < 9; i++) begin
      beat(10, (i < 3) ? i + 1 : ((i == 3) ? -1 : 0), -10, 0, 1'b0);
      pool_mode = 1'b0;
    end
    check("sum_lane0_sat", lane(out_data, 0), 31);
    check("sum_lane1", lane(out_data, 1), 5);
    check("sum_lane2_sat", lane(out_data, 2), -32);
    check("sum_lane3", lane(out_data, 3), 0);
    for (int i = 0; i < 9; i++) beat(10, 1, -10, 0, 1'b0);
    check("max_after_sum_lane0", lane(out_data, 0), 10);
    check("max_after_sum_lane1", lane(out_data, 1), 1);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pooling_stream_unit.md
Name: pooling_stream_unit

Overview:
- Streaming signed max-pooling engine; successor to the combinational 3x3 per-channel max comparator.
- Each accepted beat carries one window element for every channel. After WIN_LEN beats, or an early `in_last`, the unit emits one pooled value per channel.
- Sits between the binary conv/activation stage and the next layer's line buffer.
- Valid/ready on both sides; one output register stage.

Parameters:
- DATA_WIDTH, 6, signed two's-complement element width.
- CHANNELS, 4, parallel channel lanes.
- WIN_LEN, 9, elements per pooling window (3x3 = 9); legal range 2..255.
- CNT_WIDTH, 8, element counter width; must satisfy 2^CNT_WIDTH > WIN_LEN.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  input beat valid
- in_ready  output  1  unit accepts beat this cycle
- in_data  input  CHANNELS*DATA_WIDTH  channel c at bits [c*DATA_WIDTH +: DATA_WIDTH]
- in_last  input  1  closes current window early with this beat
- out_valid  output  1  pooled result valid
- out_ready  input  1  downstream accepts result
- out_data  output  CHANNELS*DATA_WIDTH  pooled result, same packing as in_data
- out_count  output  CNT_WIDTH  number of elements that formed the result
- busy  output  1  window partially accumulated (elem_cnt != 0)

Behaviour:
- Reset, asynchronous on rst_n low:
  - out_valid=0, out_data=0, out_count=0, busy=0.
  - elem_cnt=0; acc registers = most-negative value (-2^(DATA_WIDTH-1)).
  - in_ready follows the rule below, so it is 1 while in reset.
- Accept rule: beat accepted when in_valid && in_ready.
- in_ready = !out_valid || out_ready. The output stage is a single register that is bypassable on drain, so full throughput of one beat per cycle is sustained.
- Per accepted beat, for each lane c independently:
  - acc[c] <= signed_max(acc_eff[c], in_lane[c]).
  - acc_eff = most-negative value when elem_cnt==0, else acc.
  - Comparison is signed. On a tie, the older value is kept; the result is identical either way.
- Window close: accepted beat with elem_cnt==WIN_LEN-1 or in_last=1. On the next edge:
  - out_data <= per-lane max including the closing beat.
  - out_count <= elem_cnt+1; out_valid <= 1.
  - elem_cnt <= 0; acc reset to most-negative.
- Latency: out_valid rises 1 cycle after the closing beat is accepted.
- Non-closing beat: elem_cnt <= elem_cnt+1.
- Output handshake:
  - out_valid && out_ready with no new close that cycle: out_valid <= 0.
  - Drain and close in the same cycle: out_valid stays 1 and out_data is replaced by the new result. No bubble, no loss.
- Backpressure: while out_valid && !out_ready, in_ready=0. acc and elem_cnt hold; out_data and out_count are stable.
- in_last on the first beat: out_count=1; out_data = that beat's lanes.
- in_last asserted on the WIN_LEN-th beat: single close; no extra empty window.
- No input activity: state holds indefinitely; busy reflects a partial window.
- Reset mid-window or with a pending output: the partial window and the pending result are discarded. There is no output after reset release until a new window closes.
- Signed min value: -32 (DATA_WIDTH=6). It is a legal data value and must pool correctly. This is why initialisation is tracked via elem_cnt==0, not via a sentinel value.

Optional Feature:
- Macro: POOL_SUM_EN.
- When defined:
  - Adds input port pool_mode (1 bit), sampled on the first beat of each window and held for that window.
  - pool_mode=0 selects max pooling.
  - pool_mode=1 selects sum pooling: acc widened internally to DATA_WIDTH+CNT_WIDTH bits.
  - At close, the sum is saturated to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1] and placed in out_data.
- When undefined: no pool_mode port; max pooling only. No widened accumulator is synthesised.

Test Plan:
- Default params, 9 beats, lane0 values {3,-5,7,0,-1,2,6,-8,1}, other lanes constant -2, out_ready=1 → one cycle after beat 9: out_valid=1, lane0=7, lanes1-3=-2, out_count=9.
- All lanes all -32 for 9 beats → out_data lanes all -32, out_count=9. Confirms the sentinel-free initialisation.
- in_last on beat 4, lane0 {-3,-7,-1,-9} → lane0=-1, out_count=4. The following 9-beat window is independent (first element 5 → result ≥5).
- out_ready=0 for 5 cycles after close → out_valid, out_data, out_count stable; in_ready=0; a presented beat is not consumed. After out_ready=1, back-to-back windows of 9 beats give 2 results 9 cycles apart with no bubble.
- rst_n pulsed low after beat 5 of a window → out_valid=0, busy=0 immediately. A subsequent 9-beat window gives a result unaffected by the pre-reset data.
- POOL_SUM_EN, pool_mode=1, lane0 nine beats of 10 → out lane0=31 (saturated); lane1 {1,2,3,-1,0,0,0,0,0} → 5.
